// File: rtl/fetch_seq_pkg.sv
// Shared encodings and constants for the fetch-stage sequencer.
// Build option: FETCH_SEQ_DRAIN_EN selects whether a drain phase follows end-of-program.
package fetch_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BOOT  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        BOOT  = ST_BOOT,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int STALL_CNT_W = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/fetch_seq_load_use_detect.sv
// Load-use hazard check between the load in EX and the sources read by ID.
// Purely combinational; x0 is never a real dependency.
module load_use_detect
    import fetch_seq_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    output logic       hz
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = (ex_rd == id_rs1);
    assign rs2_match = id_uses_rs2 && (ex_rd == id_rs2);
    assign hz        = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_match || rs2_match);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control: program start, per-cycle advance/stall/flush, clean shutdown.
// Build option: FETCH_SEQ_DRAIN_EN adds a DRAIN phase and drain counter before DONE.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   end_detect,
    input  logic                   redirect,
    input  logic                   ext_hold,
    input  logic                   ex_mem_read,
    input  logic [4:0]             ex_rd,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_uses_rs2,
    output logic                   pc_select,
    output logic [31:0]            start_address,
    output logic                   stall,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   running,
    output logic                   done,
    output logic [STALL_CNT_W-1:0] stall_count,
    output state_e                 dbg_state
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       hz;
    logic       qual_end;
    logic       start_accept;

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .hz          (hz)
    );

    // An end flag seen alongside a redirect, hazard or hold belongs to a wrong or retried path.
    assign qual_end     = (state == ST_RUN) && end_detect && !redirect && !hz && !ext_hold;
    assign start_accept = start && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef FETCH_SEQ_DRAIN_EN
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    logic [DRAIN_W-1:0] drain_cnt;
    logic               drain_last;

    // Leave DRAIN on the edge where the count steps down to zero, so done
    // lands DRAIN_CYCLES cycles after the cycle that presented the end flag.
    assign drain_last = (drain_cnt <= DRAIN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (qual_end) begin
            drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
        end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_BOOT;
            ST_BOOT:  state_nxt = ST_RUN;
`ifdef FETCH_SEQ_DRAIN_EN
            ST_RUN:   if (qual_end) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_last) state_nxt = ST_DONE;
`else
            ST_RUN:   if (qual_end) state_nxt = ST_DONE;
`endif
            ST_DONE:  if (start) state_nxt = ST_BOOT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Hold outranks the hazard, and the hazard outranks a redirect.
    always_comb begin
        stall        = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        case (state)
            ST_BOOT: stall = 1'b0;
            ST_RUN: begin
                stall        = ext_hold || hz;
                id_ex_bubble = !ext_hold && hz;
                if_id_flush  = !ext_hold && !hz && redirect;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (start_accept) begin
            stall_count <= '0;
        end else if ((state == ST_RUN) && stall && (stall_count != STALL_CNT_MAX)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign pc_select     = (state == ST_BOOT);
    assign running       = (state == ST_RUN);
    assign done          = (state == ST_DONE);
    assign start_address = RESET_PC;
    assign dbg_state     = state_e'(state);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer.
// Follows FETCH_SEQ_DRAIN_EN for the end-of-program latency.
module tb_fetch_sequencer;
    import fetch_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        end_detect;
    logic        redirect;
    logic        ext_hold;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs2;
    logic        pc_select;
    logic [31:0] start_address;
    logic        stall;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        running;
    logic        done;
    logic [15:0] stall_count;
    state_e      dbg_state;

    int checks;
    int failures;

`ifdef FETCH_SEQ_DRAIN_EN
    localparam int END_LAT = 4;
`else
    localparam int END_LAT = 1;
`endif

    fetch_sequencer #(
        .RESET_PC     (32'h0000_0000),
        .DRAIN_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .end_detect    (end_detect),
        .redirect      (redirect),
        .ext_hold      (ext_hold),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs2   (id_uses_rs2),
        .pc_select     (pc_select),
        .start_address (start_address),
        .stall         (stall),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .running       (running),
        .done          (done),
        .stall_count   (stall_count),
        .dbg_state     (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       hold;
        logic       redir;
        logic       eop;
        logic       mread;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use2;
        logic       exp_stall;
        logic       exp_flush;
        logic       exp_bubble;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start       = 1'b0;
        end_detect  = 1'b0;
        redirect    = 1'b0;
        ext_hold    = 1'b0;
        ex_mem_read = 1'b0;
        ex_rd       = 5'd0;
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_uses_rs2 = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        ext_hold    = v.hold;
        redirect    = v.redir;
        end_detect  = v.eop;
        ex_mem_read = v.mread;
        ex_rd       = v.rd;
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_uses_rs2 = v.use2;
    endtask

    initial begin
        logic [15:0] exp_cnt;
        checks   = 0;
        failures = 0;

        //           name             hold redir eop mread rd     rs1    rs2    use2 stall flush bubble
        vecs[0]  = '{"idle_run",      0,   0,    0,  0,    5'd0,  5'd0,  5'd0,  0,   0,    0,    0};
        vecs[1]  = '{"hz_rs1",        0,   0,    0,  1,    5'd5,  5'd5,  5'd0,  0,   1,    0,    1};
        vecs[2]  = '{"x0_no_hz",      0,   0,    0,  1,    5'd0,  5'd0,  5'd0,  1,   0,    0,    0};
        vecs[3]  = '{"redir_and_hz",  0,   1,    0,  1,    5'd7,  5'd1,  5'd7,  1,   1,    0,    1};
        vecs[4]  = '{"redir_only",    0,   1,    0,  0,    5'd7,  5'd1,  5'd7,  1,   0,    1,    0};
        vecs[5]  = '{"hold_over_all", 1,   1,    0,  1,    5'd9,  5'd9,  5'd0,  0,   1,    0,    0};
        vecs[6]  = '{"rs2_unused",    0,   0,    0,  1,    5'd4,  5'd2,  5'd4,  0,   0,    0,    0};
        vecs[7]  = '{"no_load",       0,   0,    0,  0,    5'd3,  5'd3,  5'd3,  1,   0,    0,    0};
        vecs[8]  = '{"hold_only",     1,   0,    0,  0,    5'd0,  5'd0,  5'd0,  0,   1,    0,    0};
        vecs[9]  = '{"hz_rs2",        0,   0,    0,  1,    5'd31, 5'd1,  5'd31, 1,   1,    0,    1};
        vecs[10] = '{"eop_redir",     0,   1,    1,  0,    5'd0,  5'd0,  5'd0,  0,   0,    1,    0};
        vecs[11] = '{"eop_hz",        0,   0,    1,  1,    5'd6,  5'd6,  5'd0,  0,   1,    0,    1};

        // Reset values
        clear_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_pc_select", 32'(pc_select), 32'd0);
        chk("rst_stall", 32'(stall), 32'd1);
        chk("rst_flush", 32'(if_id_flush), 32'd0);
        chk("rst_bubble", 32'(id_ex_bubble), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall_count", 32'(stall_count), 32'd0);
        chk("start_address", start_address, 32'h0000_0000);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("idle_holds", 32'(dbg_state), 32'(ST_IDLE));

        // Start: one BOOT cycle with pc_select, then RUN
        pulse_start();
        chk("boot_pc_select", 32'(pc_select), 32'd1);
        chk("boot_stall", 32'(stall), 32'd0);
        chk("boot_running", 32'(running), 32'd0);
        tick();
        chk("run_pc_select", 32'(pc_select), 32'd0);
        chk("run_running", 32'(running), 32'd1);
        chk("run_count_zero", 32'(stall_count), 32'd0);

        // Table of RUN-state decisions; none of these may leave RUN
        exp_cnt = 16'd0;
        for (int i = 0; i < 12; i++) begin
            drive_vec(vecs[i]);
            #1;
            chk({vecs[i].name, "_stall"}, 32'(stall), 32'(vecs[i].exp_stall));
            chk({vecs[i].name, "_flush"}, 32'(if_id_flush), 32'(vecs[i].exp_flush));
            chk({vecs[i].name, "_bubble"}, 32'(id_ex_bubble), 32'(vecs[i].exp_bubble));
            if (vecs[i].exp_stall) exp_cnt = exp_cnt + 16'd1;
            tick();
            chk({vecs[i].name, "_running"}, 32'(running), 32'd1);
            chk({vecs[i].name, "_count"}, 32'(stall_count), 32'(exp_cnt));
        end
        clear_inputs();

        // start while running is ignored
        pulse_start();
        chk("start_in_run_ignored", 32'(running), 32'd1);
        chk("start_in_run_count", 32'(stall_count), 32'(exp_cnt));

        // Qualified end -> done after END_LAT cycles
        end_detect = 1'b1;
        #1;
        chk("eop_stall", 32'(stall), 32'd0);
        tick();
        end_detect = 1'b0;
        for (int k = 1; k <= END_LAT; k++) begin
            chk($sformatf("eop_done_t%0d", k), 32'(done), 32'(k == END_LAT));
            chk($sformatf("eop_running_t%0d", k), 32'(running), 32'd0);
            chk($sformatf("eop_stall_t%0d", k), 32'(stall), 32'd1);
            if (k < END_LAT) tick();
        end
        tick();
        chk("done_holds", 32'(done), 32'd1);

        // Restart from DONE clears the stall counter
        pulse_start();
        chk("restart_boot", 32'(dbg_state), 32'(ST_BOOT));
        chk("restart_count_clear", 32'(stall_count), 32'd0);
        tick();
        chk("restart_running", 32'(running), 32'd1);

        // Accumulate a stall, then reset asynchronously mid-shutdown (or mid-run)
        ext_hold = 1'b1;
        tick();
        ext_hold = 1'b0;
        chk("pre_reset_count", 32'(stall_count), 32'd1);
`ifdef FETCH_SEQ_DRAIN_EN
        end_detect = 1'b1;
        tick();
        end_detect = 1'b0;
        tick();
        chk("in_drain", 32'(dbg_state), 32'(ST_DRAIN));
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("async_rst_stall", 32'(stall), 32'd1);
        chk("async_rst_count", 32'(stall_count), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Saturation of the stall counter under a long hold
        pulse_start();
        tick();
        ext_hold = 1'b1;
        for (int n = 0; n < 65534; n++) tick();
        chk("count_near_max", 32'(stall_count), 32'h0000_FFFE);
        for (int n = 65534; n < 70000; n++) tick();
        chk("count_saturated", 32'(stall_count), 32'h0000_FFFF);
        chk("sat_still_running", 32'(running), 32'd1);
        ext_hold = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
